// File: rtl/ccff_stream_loader.sv
// ---------------------------------------------------------------------------
// ccff_stream_loader
//
// Configuration-chain driver for the I/O grid tiles. Takes the bitstream as a
// byte stream over valid/ready, serialises it MSB-first onto ccff_head with a
// matching shift enable, counts exactly CHAIN_LEN bits and only then releases
// pad isolation. Any length mismatch parks the block in ERROR with the pads
// still isolated.
//
// Ports
//   prog_clk       in   programming clock, all state on its rising edge
//   pReset_n       in   asynchronous active-low reset
//   start          in   begin a load (honoured in IDLE, DONE, ERROR)
//   s_data[7:0]    in   bitstream byte, bit 7 shifted first
//   s_valid        in   s_data valid
//   s_last         in   final byte of the bitstream (qualified by s_valid)
//   s_ready        out  byte accepted on s_valid && s_ready
//   ccff_head      out  serial data to the chain
//   ccff_shift_en  out  chain captures ccff_head on this edge (clock gate)
//   IO_ISOL_N      out  0 = pads isolated
//   busy           out  high in LOAD
//   done           out  one-cycle pulse on entry to DONE
//   err            out  high in ERROR
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start, pads isolated
// LOAD  | accepting bytes and shifting bits into the chain
// DONE  | exactly CHAIN_LEN bits loaded, pads released
// ERROR | bitstream too short or too long, pads isolated until start
// ---------------------------------------------------------------------------
module ccff_stream_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       prog_clk,
  input  logic       pReset_n,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  output logic       IO_ISOL_N,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Accepted-bit tally needs headroom for one extra byte beyond CHAIN_LEN.
  localparam int              BW    = CNT_W + 4;
  localparam logic [BW-1:0]   LEN_B = BW'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [7:0]       r_byte;
  logic             r_full;
  logic [2:0]       r_idx;
  logic [2:0]       r_end;     // index of the last used bit of the held byte
  logic             r_last;    // held byte carried s_last
  logic [CNT_W-1:0] r_cnt;
  logic [BW-1:0]    r_base;    // 8 * bytes accepted so far
  logic             r_done;

  logic             w_load;
  logic             w_shift;
  logic             w_byte_end;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_term;
  logic             w_ready;
  logic             w_accept;
  logic [BW-1:0]    w_avail;
  logic [BW-1:0]    w_rem;
  logic             w_short;
  logic             w_start_ok;

  assign w_load     = (r_state == ST_LOAD);
  assign w_shift    = w_load && r_full;
  assign w_byte_end = w_shift && (r_idx == r_end);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_term     = w_shift && (w_cnt_inc == LEN_C);

  // Refill in the same cycle the held byte's last used bit goes out, so a
  // continuously valid stream shifts without bubbles. Never accept on the
  // terminating shift: the load is over at that edge.
  assign w_ready    = w_load && (!r_full || w_byte_end) && !w_term;
  assign w_accept   = s_valid && w_ready;

  // A last byte is short if even all eight of its bits cannot reach CHAIN_LEN.
  assign w_avail    = r_base + BW'(8);
  assign w_short    = w_accept && s_last && (w_avail < LEN_B);

  // Bits of the last byte actually used, minus one; 0..7 whenever not short.
  assign w_rem      = LEN_B - r_base - BW'(1);

  assign w_start_ok = start && !w_load;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_term) begin
          w_next = r_last ? ST_DONE : ST_ERROR;
        end else if (w_short) begin
          w_next = ST_ERROR;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Byte register, bit index and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_byte <= 8'd0;
      r_full <= 1'b0;
      r_idx  <= 3'd0;
      r_end  <= 3'd0;
      r_last <= 1'b0;
      r_cnt  <= '0;
      r_base <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_load && (w_next == ST_DONE);

      if (w_start_ok) begin
        r_byte <= 8'd0;
        r_full <= 1'b0;
        r_idx  <= 3'd0;
        r_end  <= 3'd0;
        r_last <= 1'b0;
        r_cnt  <= '0;
        r_base <= '0;
      end else if (w_load) begin
        if (w_shift) begin
          r_cnt <= w_cnt_inc;
        end

        if (w_next != ST_LOAD) begin
          // Leaving LOAD: drop the held byte so nothing more is shifted.
          r_full <= 1'b0;
        end else begin
          if (w_shift) begin
            r_idx <= r_idx + 3'd1;
            if (w_byte_end) begin
              r_full <= 1'b0;
            end
          end
          if (w_accept) begin
            r_byte <= s_data;
            r_full <= 1'b1;
            r_idx  <= 3'd0;
            r_last <= s_last;
            r_end  <= s_last ? w_rem[2:0] : 3'd7;
            r_base <= w_avail;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign s_ready       = w_ready;
  assign ccff_shift_en = w_shift;
  assign ccff_head     = w_shift & r_byte[3'd7 - r_idx];
  assign IO_ISOL_N     = (r_state == ST_DONE);
  assign busy          = w_load;
  assign err           = (r_state == ST_ERROR);
  assign done          = r_done;

endmodule

// File: tb/tb_ccff_stream_loader.sv
module tb_ccff_stream_loader;

  logic       prog_clk = 1'b0;
  logic       pReset_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic [2:0] start;
  logic [2:0] ready, head, sen, isol, busy, done, err;

  always #5 prog_clk = ~prog_clk;

  // Three chain lengths share the stream; only the one started consumes it.
  ccff_stream_loader #(.CHAIN_LEN(12)) u12 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start[0]),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(ready[0]),
    .ccff_head(head[0]), .ccff_shift_en(sen[0]), .IO_ISOL_N(isol[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]));

  ccff_stream_loader #(.CHAIN_LEN(16)) u16 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start[1]),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(ready[1]),
    .ccff_head(head[1]), .ccff_shift_en(sen[1]), .IO_ISOL_N(isol[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]));

  ccff_stream_loader #(.CHAIN_LEN(8)) u8 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start[2]),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(ready[2]),
    .ccff_head(head[2]), .ccff_shift_en(sen[2]), .IO_ISOL_N(isol[2]),
    .busy(busy[2]), .done(done[2]), .err(err[2]));

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int shift_cnt = 0;
  int run_len = 0;
  int max_run = 0;
  int wc;
  bit exp_q[$];
  bit mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_start(input int d);
    sel = d;
    shift_cnt = 0;
    run_len = 0;
    max_run = 0;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic push_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[7-i]);
  endtask

  task automatic send(input logic [7:0] v, input logic last, output int waited);
    s_data  = v;
    s_last  = last;
    s_valid = 1'b1;
    waited  = 0;
    while (!ready[sel] && waited < 100) begin
      tick();
      waited++;
    end
    chk("send_ready_timeout", 32'(waited < 100), 1);
    tick();
  endtask

  task automatic wait_done(input string tag);
    int   n;
    logic prev;
    n = 0;
    prev = sen[sel];
    while (!done[sel] && n < 60) begin
      prev = sen[sel];
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(done[sel]), 1);
    chk({tag, "_isol_up"}, 32'(isol[sel]), 1);
    chk({tag, "_shift_before_done"}, 32'(prev), 1);
    tick();
    chk({tag, "_done_one_cycle"}, 32'(done[sel]), 0);
    chk({tag, "_isol_hold"}, 32'(isol[sel]), 1);
    chk({tag, "_ready_in_done"}, 32'(ready[sel]), 0);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
  endtask

  // Scoreboard: every shift of the selected DUT pops one expected bit.
  always @(negedge prog_clk) begin
    if (sen[sel]) begin
      shift_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_shift observed=%0d expected=%0d", shift_cnt, shift_cnt - 1);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        assert (head[sel] === mon_e) else begin
          errors++;
          $error("FAIL ccff_head bit%0d observed=%b expected=%b", shift_cnt, head[sel], mon_e);
        end
      end
      checks++;
      assert (isol[sel] === 1'b0) else begin
        errors++;
        $error("FAIL isol_during_shift observed=%b expected=0", isol[sel]);
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    pReset_n = 1'b0;
    start    = 3'b000;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    s_last   = 1'b0;
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", 32'(ready[d]), 0);
      chk("rst_head",  32'(head[d]),  0);
      chk("rst_sen",   32'(sen[d]),   0);
      chk("rst_isol",  32'(isol[d]),  0);
      chk("rst_busy",  32'(busy[d]),  0);
      chk("rst_done",  32'(done[d]),  0);
      chk("rst_err",   32'(err[d]),   0);
    end
    @(negedge prog_clk);
    pReset_n = 1'b1;
    tick();

    // Normal load, CHAIN_LEN=12: 0xA5 then 0x30 with last
    do_start(0);
    chk("norm_busy",  32'(busy[0]),  1);
    chk("norm_ready", 32'(ready[0]), 1);
    chk("norm_isol",  32'(isol[0]),  0);
    push_bits(8'hA5, 8);
    send(8'hA5, 1'b0, wc);
    push_bits(8'h30, 4);
    send(8'h30, 1'b1, wc);
    s_valid = 1'b0;
    wait_done("norm");
    chk("norm_shifts", 32'(shift_cnt), 12);
    chk("norm_contig", 32'(max_run), 12);

    // Back-to-back, CHAIN_LEN=16: 0xFF then 0x00 with last, valid held
    do_start(1);
    push_bits(8'hFF, 8);
    send(8'hFF, 1'b0, wc);
    push_bits(8'h00, 8);
    send(8'h00, 1'b1, wc);
    chk("b2b_ready_on_cycle8", 32'(wc), 7);
    chk("b2b_ready_after_2nd", 32'(ready[1]), 0);
    s_valid = 1'b0;
    wait_done("b2b");
    chk("b2b_shifts", 32'(shift_cnt), 16);
    chk("b2b_contig", 32'(max_run), 16);

    // Stall between bytes, CHAIN_LEN=12
    do_start(0);
    push_bits(8'hA5, 8);
    send(8'hA5, 1'b0, wc);
    s_valid = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_sen", 32'(sen[0]), 0);
      chk("stall_cnt", 32'(u12.r_cnt), 8);
      tick();
    end
    push_bits(8'h3C, 4);
    send(8'h3C, 1'b1, wc);
    s_valid = 1'b0;
    wait_done("stall");
    chk("stall_shifts", 32'(shift_cnt), 12);
    chk("stall_run", 32'(max_run), 8);

    // Too short, CHAIN_LEN=16: single 0x5A with last
    do_start(1);
    send(8'h5A, 1'b1, wc);
    s_valid = 1'b0;
    chk("short_err",   32'(err[1]),   1);
    chk("short_isol",  32'(isol[1]),  0);
    chk("short_ready", 32'(ready[1]), 0);
    chk("short_busy",  32'(busy[1]),  0);
    repeat (3) tick();
    chk("short_err_hold", 32'(err[1]), 1);
    chk("short_shifts_le8", 32'(shift_cnt <= 8), 1);
    do_start(1);
    chk("short_restart_err",  32'(err[1]),  0);
    chk("short_restart_busy", 32'(busy[1]), 1);

    // Too long, CHAIN_LEN=8: 0x81 without last
    do_start(2);
    push_bits(8'h81, 8);
    send(8'h81, 1'b0, wc);
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("long_ready_low", 32'(ready[2]), 0);
      tick();
    end
    chk("long_err",    32'(err[2]),  1);
    chk("long_isol",   32'(isol[2]), 0);
    chk("long_shifts", 32'(shift_cnt), 8);
    chk("long_queue_empty", 32'(exp_q.size()), 0);
    s_valid = 1'b1;
    s_data  = 8'hEE;
    repeat (2) tick();
    chk("long_ready_in_err", 32'(ready[2]), 0);
    chk("long_sen_in_err",   32'(sen[2]),   0);
    s_valid = 1'b0;

    // Reset mid-LOAD, CHAIN_LEN=16
    pReset_n = 1'b0;
    tick();
    @(negedge prog_clk);
    pReset_n = 1'b1;
    tick();
    do_start(1);
    push_bits(8'hC9, 5);
    send(8'hC9, 1'b0, wc);
    s_valid = 1'b0;
    repeat (5) tick();
    pReset_n = 1'b0;
    #1;
    chk("mrst_sen",   32'(sen[1]),   0);
    chk("mrst_ready", 32'(ready[1]), 0);
    chk("mrst_busy",  32'(busy[1]),  0);
    chk("mrst_isol",  32'(isol[1]),  0);
    chk("mrst_shifts", 32'(shift_cnt), 5);
    chk("mrst_queue_empty", 32'(exp_q.size()), 0);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    tick();
    chk("mrst_idle_busy", 32'(busy[1]), 0);
    chk("mrst_idle_err",  32'(err[1]),  0);
    chk("mrst_idle_ready", 32'(ready[1]), 0);
    do_start(1);
    push_bits(8'h12, 8);
    send(8'h12, 1'b0, wc);
    push_bits(8'h34, 8);
    send(8'h34, 1'b1, wc);
    s_valid = 1'b0;
    wait_done("mrst_reload");
    chk("mrst_reload_shifts", 32'(shift_cnt), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
